y86_stage_ctrl: RTL
===================

# y86_stage_ctrl

Multi-cycle stage sequencer for the Y86-64 sequential processor. It steps one instruction at a time through Fetch, Decode, Execute, Memory, Writeback and PC-update, issuing a one-cycle enable to each datapath stage. It owns the request/acknowledge handshake to the shared instruction/data memory and tracks architectural status (AOK/HLT/ADR/INS). It sits between the `y86wrap` datapath and its memory, replacing free-running per-clock stage evaluation.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: number of wait cycles without `mem_ack` before an ADR fault is declared. Used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level input; continuous execution while high.
- `step` in 1: executes one instruction; sampled only in IDLE.
- `icode` in 4: instruction code from fetch logic; valid in the `fetch_en` cycle.
- `imem_err` in 1: instruction memory error; valid in the `fetch_en` cycle.
- `instr_valid` in 1: valid instruction; valid in the `fetch_en` cycle.
- `dmem_err` in 1: data memory error; valid in the `mem_en` cycle.
- `mem_ack` in 1: memory acknowledge.
- `mem_req` out 1: memory request.
- `mem_is_data` out 1: 1 for a data access, 0 for an instruction fetch.
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`, `pc_en` out 1 each: one-cycle stage strobes.
- `stat` out 2: architectural status. 00 = AOK, 01 = HLT, 10 = ADR, 11 = INS.
- `busy` out 1: high in every state except IDLE and HALT.
- `instr_count` out 32: count of retired instructions.
- `state` out 3: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCUP=6, HALT=7.

## Operation
State transitions:
- **IDLE:** if `run` or `step` → FETCH; otherwise stay.
- **FETCH:**
  - `mem_req`=1, `mem_is_data`=0.
  - On `mem_ack`: `fetch_en`=1 and `icode` is latched internally.
  - If `imem_err` → `stat`=10, go to HALT.
  - Else if `!instr_valid` → `stat`=11, go to HALT.
  - Else → DECODE.
- **DECODE:** `decode_en`=1.
  - If latched icode = 0 (halt): `stat`=01, `instr_count`++, go to HALT.
  - Otherwise → EXEC.
- **EXEC:** `exec_en`=1.
  - Latched icode ∈ {4, 5, 8, 9, A, B} → MEM.
  - Otherwise → WB.
- **MEM:**
  - `mem_req`=1, `mem_is_data`=1.
  - On `mem_ack`: `mem_en`=1. If `dmem_err` → `stat`=10, go to HALT (no WB, no PC update). Otherwise → WB.
- **WB:** `wb_en`=1, then → PCUP.
- **PCUP:** `pc_en`=1, `instr_count`++.
  - If `run` → FETCH.
  - Otherwise → IDLE.
- **HALT:** terminal. All strobes and `mem_req` stay 0; `stat` holds. Only reset leaves this state.

Signal rules:
- `fetch_en` = (FETCH && `mem_ack`) and `mem_en` = (MEM && `mem_ack`); these two are Mealy outputs.
- All other strobes, `mem_req` and `mem_is_data` decode from the state register alone.

Boundary rules:
- `run` falling mid-instruction: the current instruction completes, then the block returns to IDLE.
- `step` outside IDLE is ignored. `step` and `run` together in IDLE behave as `run`.
- `instr_count` wraps from 2^32−1 to 0.
- `mem_ack` outside FETCH/MEM is ignored.
- `stat` changes only on entry to HALT.

## Timing
- Reset (asynchronous): `state`=IDLE, `stat`=00, `instr_count`=0, all strobes 0, `mem_req` 0, `mem_is_data` 0, `busy` 0, latched icode 0, wait counter 0.
- Reset asserted mid-instruction aborts the instruction immediately: no `pc_en`, no count increment.
- Latency, with `mem_ack` high on the first request cycle:
  - Non-memory instruction: 5 cycles, FETCH → PCUP.
  - Memory instruction: 6 cycles.
  - Each cycle `mem_ack` is withheld adds one cycle.
- Back-to-back with `run`=1: FETCH follows PCUP with no idle cycle.
- Handshake: `mem_req` stays high until the cycle `mem_ack` is sampled high. It drops in the following cycle, or stays high if the next state is MEM/FETCH with a new request.

## Configuration
- `STAGE_CTRL_TIMEOUT_EN` defined:
  - A wait counter increments on each FETCH/MEM cycle with `mem_ack`=0 and clears on ack or state change.
  - When it reaches `MEM_TIMEOUT`: `stat`=10, go to HALT with no strobe that cycle.
- Undefined: no counter is built, and the block waits indefinitely for `mem_ack`.

## Test plan
- Reset, `run`=1, `icode`=6, `mem_ack` tied 1 → `fetch_en`, `decode_en`, `exec_en`, `wb_en`, `pc_en` on consecutive cycles 1–5; `instr_count`=1 after cycle 5; FETCH again on cycle 6.
- `icode`=5, MEM-stage `mem_ack` delayed 2 cycles → `mem_req`/`mem_is_data` high 3 cycles; single `mem_en` pulse on the ack cycle; instruction takes 8 cycles.
- `icode`=0 → `stat`=01, `state`=7, `busy`=0, `instr_count`=1; no further `mem_req` for 20 cycles despite `run`=1.
- `imem_err`=1 at fetch ack → `stat`=10, HALT, no `decode_en`. Separate run with `instr_valid`=0 → `stat`=11. Separate run with `dmem_err` at MEM ack → `stat`=10, no `wb_en`/`pc_en`.
- `run`=0, one-cycle `step` in IDLE → exactly one instruction, then IDLE, `instr_count`=1. A `step` pulse during EXEC is ignored. Reset during MEM → all outputs return to reset values asynchronously.
- With the macro defined, `MEM_TIMEOUT`=4, `mem_ack` held 0 → HALT with `stat`=10 after 4 wait cycles. With the macro undefined → still in FETCH after 100 cycles.

Source files
------------

// File: rtl/y86_stage_ctrl.sv
// Y86-64 multi-cycle stage sequencer: one-cycle stage strobes, memory req/ack, status, retire count.
// Latency: 5 cycles FETCH->PCUP (6 with a MEM stage), plus one cycle per withheld mem_ack.
// Backpressure: holds FETCH/MEM with mem_req high until mem_ack; STAGE_CTRL_TIMEOUT_EN adds an ADR timeout.
module y86_stage_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic [3:0]  icode,
    input  logic        imem_err,
    input  logic        instr_valid,
    input  logic        dmem_err,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_is_data,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic [1:0]  stat,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  stat_q, stat_d;
    logic [3:0]  icode_q, icode_d;
    logic [31:0] count_q;
    logic        count_inc;
    logic        is_mem_op;
    logic        waiting;
    logic        timeout_hit;

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;

`ifdef STAGE_CTRL_TIMEOUT_EN
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;

    // Trips on the MEM_TIMEOUT-th consecutive unacknowledged cycle.
    assign timeout_hit = waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (waiting && (state_d == state_q)) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (MEM_TIMEOUT != 0) && waiting;
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        is_mem_op = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_op = 1'b1;
            default:                            is_mem_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stat_d      = stat_q;
        icode_d     = icode_q;
        count_inc   = 1'b0;
        mem_req     = 1'b0;
        mem_is_data = 1'b0;
        fetch_en    = 1'b0;
        decode_en   = 1'b0;
        exec_en     = 1'b0;
        mem_en      = 1'b0;
        wb_en       = 1'b0;
        pc_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || step) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    fetch_en = 1'b1;
                    icode_d  = icode;
                    if (imem_err) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (!instr_valid) begin
                        stat_d  = STAT_INS;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_DECODE;
                    end
                end else if (timeout_hit) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                if (icode_q == 4'h0) begin
                    stat_d    = STAT_HLT;
                    count_inc = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                state_d = is_mem_op ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                if (mem_ack) begin
                    mem_en = 1'b1;
                    if (dmem_err) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                wb_en   = 1'b1;
                state_d = S_PCUP;
            end
            S_PCUP: begin
                pc_en     = 1'b1;
                count_inc = 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= 4'h0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            if (count_inc) count_q <= count_q + 32'd1;
        end
    end

    assign stat        = stat_q;
    assign instr_count = count_q;
    assign state       = state_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule
